// File: rtl/adder_4bit_structural.sv
// ---------------------------------------------------------------------------
// adder_4bit_structural
//
// A 4-bit ripple-carry adder built from gate-level full-adder cells. It has
// two result paths:
//   * a combinational sum/carry/overflow path, for chaining inside array
//     multipliers and similar structures;
//   * a registered copy of that result, with a one-cycle valid strobe, for
//     pipelined use.
//
// Ports:
//   clk      in   1  rising-edge clock for the output register stage
//   rst_n    in   1  asynchronous active-low reset (registered outputs only)
//   a        in   4  addend A (unsigned; two's complement for ovf)
//   b        in   4  addend B
//   cin      in   1  carry into bit 0
//   en       in   1  capture enable for the register stage
//   sum      out  4  combinational (a+b+cin)[3:0]
//   cout     out  1  combinational (a+b+cin)[4]
//   ovf      out  1  combinational signed overflow (carry into bit 3 ^ carry out)
//   sum_q    out  4  registered sum
//   cout_q   out  1  registered carry-out
//   ovf_q    out  1  registered signed overflow
//   valid_q  out  1  high for exactly one cycle after each capture
// ---------------------------------------------------------------------------

// One full-adder cell, described purely with gate primitives.
//
// Ports:
//   a, b, ci  in   1  operand bits and carry in
//   s         out  1  sum bit  = a ^ b ^ ci
//   co        out  1  carry    = (a & b) | (ci & (a ^ b))
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_xor;
  logic ab_and;
  logic prop_and;

  xor g_xor_ab  (ab_xor,   a,      b);
  xor g_xor_sum (s,        ab_xor, ci);
  and g_and_gen (ab_and,   a,      b);
  // Reusing a ^ b as the propagate term keeps the carry logic to one
  // AND-OR level on top of the sum XOR.
  and g_and_prp (prop_and, ci,     ab_xor);
  or  g_or_co   (co,       ab_and, prop_and);

endmodule

module adder_4bit_structural (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       en,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic [3:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q,
  output logic       valid_q
);

  // carry[i] is the carry into bit i; carry[4] is the final carry-out.
  logic [4:0] carry;
  logic [3:0] sum_bits;
  logic       ovf_bit;

  assign carry[0] = cin;

  // Ripple chain: each cell feeds its carry straight into the next bit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_cell
      full_adder_cell u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (carry[gi]),
        .s  (sum_bits[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Signed overflow happens exactly when the carry into the sign bit differs
  // from the carry out of it.
  xor g_xor_ovf (ovf_bit, carry[3], carry[4]);

  assign sum  = sum_bits;
  assign cout = carry[4];
  assign ovf  = ovf_bit;

  // -------------------------------------------------------------------------
  // Output register stage
  // -------------------------------------------------------------------------
  logic [3:0] sum_reg,   sum_next;
  logic       cout_reg,  cout_next;
  logic       ovf_reg,   ovf_next;
  logic       valid_reg, valid_next;

  // Result fields load only on an enabled edge; valid is a single-cycle
  // strobe, so it drops on any edge without en.
  always_comb begin
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    valid_next = 1'b0;
    if (en) begin
      sum_next   = sum_bits;
      cout_next  = carry[4];
      ovf_next   = ovf_bit;
      valid_next = 1'b1;
    end
  end

  // Reset clears the registered copy immediately and discards any captured
  // result; the combinational path above is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= 4'd0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      valid_reg <= valid_next;
    end
  end

  assign sum_q   = sum_reg;
  assign cout_q  = cout_reg;
  assign ovf_q   = ovf_reg;
  assign valid_q = valid_reg;

endmodule

// File: tb/tb_adder_4bit_structural.sv
// ---------------------------------------------------------------------------
// tb_adder_4bit_structural
//
// Directed, self-checking bench for adder_4bit_structural: exhaustive
// combinational sweep against an independent signed/unsigned reference,
// the hand-computed boundary vectors, register latency/hold, and the
// asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_adder_4bit_structural;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       en;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       ovf_q;
  logic       valid_q;

  int n_checks;
  int n_pass;

  adder_4bit_structural dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .en      (en),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf),
    .sum_q   (sum_q),
    .cout_q  (cout_q),
    .ovf_q   (ovf_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
    n_checks++;
    if (obs === exp_val) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
    end
  endtask

  // Drives one combinational vector and checks it against hand values.
  task automatic comb_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic vc, input logic [3:0] es, input logic ec,
                          input logic eo);
    a = va; b = vb; cin = vc;
    #1;
    $display("txn %s: a=%0d b=%0d cin=%0d -> sum=%b cout=%b ovf=%b", tag, va, vb, vc,
             sum, cout, ovf);
    check({tag, "_sum"},  {4'd0, sum},  {4'd0, es});
    check({tag, "_cout"}, {7'd0, cout}, {7'd0, ec});
    check({tag, "_ovf"},  {7'd0, ovf},  {7'd0, eo});
  endtask

  task automatic check_regs(input string tag, input logic [3:0] es, input logic ec,
                            input logic eo, input logic ev);
    $display("txn %s: sum_q=%b cout_q=%b ovf_q=%b valid_q=%b", tag, sum_q, cout_q,
             ovf_q, valid_q);
    check({tag, "_sum_q"},   {4'd0, sum_q},   {4'd0, es});
    check({tag, "_cout_q"},  {7'd0, cout_q},  {7'd0, ec});
    check({tag, "_ovf_q"},   {7'd0, ovf_q},   {7'd0, eo});
    check({tag, "_valid_q"}, {7'd0, valid_q}, {7'd0, ev});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b1;
    en    = 1'b0;
    a = 4'd0; b = 4'd0; cin = 1'b0;

    // Asynchronous reset from power-up, asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_regs("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Registers hold zero across an edge while reset is held, even with en=1.
    en = 1'b1; a = 4'd3; b = 4'd4;
    @(negedge clk);
    check_regs("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational sweep against an arithmetic reference.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int sa, sb, ssum, usum;
          logic [4:0] exp_full;
          logic exp_ovf;
          a = ai[3:0]; b = bi[3:0]; cin = ci[0];
          #1;
          usum = ai + bi + ci;
          exp_full = usum[4:0];
          sa = (ai > 7) ? ai - 16 : ai;
          sb = (bi > 7) ? bi - 16 : bi;
          ssum = sa + sb + ci;
          exp_ovf = (ssum > 7) || (ssum < -8);
          check("sweep_sum", {3'd0, cout, sum}, {3'd0, exp_full});
          check("sweep_ovf", {7'd0, ovf}, {7'd0, exp_ovf});
        end
      end
    end
    $display("txn sweep: 512 vectors checked");

    // Directed boundary vectors.
    @(negedge clk);
    comb_vec("zero",     4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0);
    comb_vec("max",      4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0);
    comb_vec("7p1",      4'd7,  4'd1,  1'b0, 4'b1000, 1'b0, 1'b1);
    comb_vec("8p8",      4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1);
    comb_vec("2p2",      4'd2,  4'd2,  1'b0, 4'b0100, 1'b0, 1'b0);
    comb_vec("15p14",    4'd15, 4'd14, 1'b0, 4'b1101, 1'b1, 1'b0);
    comb_vec("ripple",   4'd15, 4'd0,  1'b1, 4'b0000, 1'b1, 1'b0);
    comb_vec("noripple", 4'd15, 4'd0,  1'b0, 4'b1111, 1'b0, 1'b0);

    // Register latency: one enabled edge, then en=0 with new inputs.
    @(negedge clk);
    a = 4'd9; b = 4'd5; cin = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0; a = 4'd1; b = 4'd1; cin = 1'b0;
    check_regs("capture", 4'b1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_regs("hold", 4'b1111, 1'b0, 1'b0, 1'b0);

    // Capture 15+14, then hit reset between edges.
    a = 4'd15; b = 4'd14; cin = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_regs("cap_15p14", 4'b1101, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_regs("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst_comb_sum", {4'd0, sum}, 8'h0d);
    check("rst_comb_cout", {7'd0, cout}, 8'h01);

    // Release with en=1; capture resumes on the next edge.
    @(negedge clk);
    a = 4'd8; b = 4'd8; cin = 1'b0; en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_regs("resume", 4'b0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_regs("resume_hold", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
